// File: rtl/harness_exit_pkg.sv
// Shared command, exit-code and state definitions for the harness exit monitor.
package harness_exit_pkg;

  localparam logic [7:0] CMD_EXIT      = 8'h00;
  localparam logic [7:0] CMD_CONSOLE   = 8'h01;
  localparam logic [7:0] CMD_HEARTBEAT = 8'h02;

  localparam logic [30:0] CODE_WATCHDOG = 31'h7FFF_FFFF;
  localparam logic [30:0] CODE_BADCMD   = 31'h7FFF_FFFE;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DRAIN     = 2'd1,
    DONE_PASS = 2'd2,
    DONE_FAIL = 2'd3
  } exit_state_e;

endpackage

// File: rtl/harness_exit_monitor_if.sv
// Tohost request channel and console byte channel between the DUT side and the exit monitor.
interface harness_exit_monitor_if;
  logic        io_tohost_valid;
  logic        io_tohost_ready;
  logic [63:0] io_tohost_bits;
  logic        io_console_valid;
  logic        io_console_ready;
  logic [7:0]  io_console_bits;

  modport master (
    output io_tohost_valid, io_tohost_bits, io_console_ready,
    input  io_tohost_ready, io_console_valid, io_console_bits
  );

  modport slave (
    input  io_tohost_valid, io_tohost_bits, io_console_ready,
    output io_tohost_ready, io_console_valid, io_console_bits
  );
endinterface

// File: rtl/exit_mon_fifo.sv
// Small synchronous FIFO buffering console bytes; DEPTH must be a power of two.
module exit_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/harness_exit_monitor.sv
// Test-completion monitor: decodes tohost words into exit/console/heartbeat, latches pass/fail, watchdog.
// Console FIFO and console channel exist only when HARNESS_CONSOLE_EN is defined.
//
// state     | meaning
// RUN       | accepting tohost words, watchdog counting
// DRAIN     | exit decided, waiting for console FIFO to empty
// DONE_PASS | io_success held until reset
// DONE_FAIL | io_failure and io_exit_code held until reset
module harness_exit_monitor
  import harness_exit_pkg::*;
#(
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd1000000,
  parameter int          CONSOLE_DEPTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  harness_exit_monitor_if.slave tohost,
  output logic                  io_success,
  output logic                  io_failure,
  output logic [30:0]           io_exit_code
);
`ifdef HARNESS_CONSOLE_EN
  localparam bit CONSOLE_EN = 1'b1;
`else
  localparam bit CONSOLE_EN = 1'b0;
`endif

  exit_state_e state_q, state_d;
  logic [30:0] code_q, code_d;
  logic [31:0] wdog_q, wdog_d;
  logic        accept, wdog_expired;
  logic        fifo_push, fifo_full, fifo_empty;
  logic [7:0]  cmd;

  assign cmd                     = tohost.io_tohost_bits[63:56];
  assign tohost.io_tohost_ready  = (state_q == RUN) && !fifo_full;
  assign accept                  = tohost.io_tohost_valid && tohost.io_tohost_ready;
  assign wdog_expired            = (WATCHDOG_CYCLES != 32'd0) &&
                                   (wdog_q == WATCHDOG_CYCLES - 32'd1);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    wdog_d    = wdog_q;
    fifo_push = 1'b0;
    case (state_q)
      RUN: begin
        if (accept) begin
          wdog_d = '0;
          case (cmd)
            CMD_EXIT: begin
              if (tohost.io_tohost_bits[0]) begin
                code_d  = tohost.io_tohost_bits[31:1];
                state_d = DRAIN;
              end
            end
            CMD_CONSOLE:   fifo_push = CONSOLE_EN;
            CMD_HEARTBEAT: ;
            default: begin
              code_d  = CODE_BADCMD;
              state_d = DRAIN;
            end
          endcase
        end else begin
          wdog_d = wdog_q + 32'd1;
          if (wdog_expired) begin
            code_d  = CODE_WATCHDOG;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) state_d = (code_q == '0) ? DONE_PASS : DONE_FAIL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      code_q  <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      wdog_q  <= wdog_d;
    end
  end

  assign io_success   = (state_q == DONE_PASS);
  assign io_failure   = (state_q == DONE_FAIL);
  assign io_exit_code = io_failure ? code_q : '0;

  logic unused_payload;
  assign unused_payload = &{1'b0, tohost.io_tohost_bits[55:32]};

`ifdef HARNESS_CONSOLE_EN
  logic fifo_pop;
  assign fifo_pop                = tohost.io_console_valid && tohost.io_console_ready;
  assign tohost.io_console_valid = !fifo_empty;

  exit_mon_fifo #(
    .WIDTH(8),
    .DEPTH(CONSOLE_DEPTH)
  ) u_console_fifo (
    .clk_i  (clock),
    .rst_i  (reset),
    .push_i (fifo_push),
    .data_i (tohost.io_tohost_bits[7:0]),
    .pop_i  (fifo_pop),
    .data_o (tohost.io_console_bits),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );
`else
  assign fifo_full               = 1'b0;
  assign fifo_empty              = 1'b1;
  assign tohost.io_console_valid = 1'b0;
  assign tohost.io_console_bits  = '0;

  logic unused_console;
  assign unused_console = &{1'b0, tohost.io_console_ready, fifo_push, CONSOLE_DEPTH[0]};
`endif
endmodule
